// File: rtl/soc_system_pio_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : soc_system_pio_pkg
//  Purpose  : Register map and shared types for the blinking output PIO.
//  Revision : 1.0  initial release
// ============================================================================

package soc_system_pio_pkg;

    localparam int REG_ADDR_W = 3;
    localparam int BUS_DATA_W = 32;

    typedef logic [REG_ADDR_W-1:0] pio_addr_t;

    localparam pio_addr_t ADDR_DATA         = 3'd0;
    localparam pio_addr_t ADDR_BLINK_MASK   = 3'd1;
    localparam pio_addr_t ADDR_BLINK_PERIOD = 3'd2;
    localparam pio_addr_t ADDR_STATUS       = 3'd3;
    localparam pio_addr_t ADDR_OUTSET       = 3'd4;
    localparam pio_addr_t ADDR_OUTCLEAR     = 3'd5;

    localparam int PHASE_BIT = 0;

endpackage : soc_system_pio_pkg

`default_nettype wire

// File: rtl/soc_system_pio_blink_if.sv
`default_nettype none
// ============================================================================
//  Module   : soc_system_pio_blink_if
//  Purpose  : Avalon-MM slave bus bundle for the blinking output PIO.
//  Revision : 1.0  initial release
// ============================================================================

interface soc_system_pio_blink_if;
    import soc_system_pio_pkg::*;

    pio_addr_t               address;
    logic                    chipselect;
    logic                    write_n;
    logic [BUS_DATA_W-1:0]   writedata;
    logic [BUS_DATA_W-1:0]   readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface : soc_system_pio_blink_if

`default_nettype wire

// File: rtl/soc_system_blink_prescaler.sv
`default_nettype none
// ============================================================================
//  Module   : soc_system_blink_prescaler
//  Purpose  : Half-period counter producing the shared blink phase.
//  Revision : 1.0  initial release
// ============================================================================

module soc_system_blink_prescaler
    import soc_system_pio_pkg::*;
#(
    parameter int PRESCALE_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PRESCALE_W-1:0] period,
    input  logic                  load,
    output logic                  phase
);

    logic [PRESCALE_W-1:0] cnt_q;
    logic [PRESCALE_W-1:0] cnt_d;
    logic                  phase_q;
    logic                  phase_d;

    // A period write restarts the count and wins over a coincident terminal count.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (load) begin
            cnt_d = '0;
        end else if (period == '0) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == period - PRESCALE_W'(1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule : soc_system_blink_prescaler

`default_nettype wire

// File: rtl/soc_system_pio_blink.sv
`default_nettype none
// ============================================================================
//  Module   : soc_system_pio_blink
//  Purpose  : Avalon-MM output PIO with atomic set/clear and optional
//             per-channel blink engine (enabled by macro PIO_BLINK_EN).
//  Revision : 1.0  initial release
// ============================================================================

module soc_system_pio_blink
    import soc_system_pio_pkg::*;
#(
    parameter int          WIDTH        = 8,
    parameter logic [31:0] RESET_VALUE  = 32'h0000_007F,
    parameter int          PRESCALE_W   = 32,
    parameter logic [31:0] PERIOD_RESET = 32'd25000000
) (
    input  logic                    clk,
    input  logic                    reset,
    soc_system_pio_blink_if.slave   avs,
    output logic [WIDTH-1:0]        out_port
);

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] blink_out;
    logic             unused_wdata;

    assign wr_en        = avs.chipselect & ~avs.write_n;
    assign wr_data      = avs.writedata[WIDTH-1:0];
    assign unused_wdata = ^avs.writedata;

    always_comb begin
        data_d = data_q;
        if (wr_en) begin
            case (avs.address)
                ADDR_DATA:     data_d = wr_data;
                ADDR_OUTSET:   data_d = data_q | wr_data;
                ADDR_OUTCLEAR: data_d = data_q & ~wr_data;
                default:       data_d = data_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= RESET_VALUE[WIDTH-1:0];
        end else begin
            data_q <= data_d;
        end
    end

`ifdef PIO_BLINK_EN
    logic [WIDTH-1:0]      blink_mask_q;
    logic [WIDTH-1:0]      blink_mask_d;
    logic [PRESCALE_W-1:0] period_q;
    logic [PRESCALE_W-1:0] period_d;
    logic                  period_load;
    logic                  phase;

    assign period_load = wr_en && (avs.address == ADDR_BLINK_PERIOD);

    always_comb begin
        blink_mask_d = blink_mask_q;
        period_d     = period_q;
        if (wr_en && (avs.address == ADDR_BLINK_MASK)) begin
            blink_mask_d = wr_data;
        end
        if (period_load) begin
            period_d = avs.writedata[PRESCALE_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_mask_q <= '0;
            period_q     <= PERIOD_RESET[PRESCALE_W-1:0];
        end else begin
            blink_mask_q <= blink_mask_d;
            period_q     <= period_d;
        end
    end

    soc_system_blink_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .period (period_q),
        .load   (period_load),
        .phase  (phase)
    );

    assign blink_out = blink_mask_q & {WIDTH{phase}};
`else
    logic [PRESCALE_W-1:0] unused_period_rst;

    assign unused_period_rst = PERIOD_RESET[PRESCALE_W-1:0];
    assign blink_out         = '0;
`endif

    // Read mux is purely address-driven; chipselect does not gate it.
    always_comb begin
        avs.readdata = '0;
        case (avs.address)
            ADDR_DATA:         avs.readdata = BUS_DATA_W'(data_q);
`ifdef PIO_BLINK_EN
            ADDR_BLINK_MASK:   avs.readdata = BUS_DATA_W'(blink_mask_q);
            ADDR_BLINK_PERIOD: avs.readdata = BUS_DATA_W'(period_q);
            ADDR_STATUS:       avs.readdata[PHASE_BIT] = phase;
`endif
            default:           avs.readdata = '0;
        endcase
    end

    assign out_port = data_q ^ blink_out;

endmodule : soc_system_pio_blink

`default_nettype wire

// File: tb/tb_soc_system_pio_blink.sv
`default_nettype none
// ============================================================================
//  Module   : tb_soc_system_pio_blink
//  Purpose  : Scoreboard bench for soc_system_pio_blink (default parameters).
//  Revision : 1.0  initial release
// ============================================================================

module tb_soc_system_pio_blink;
    import soc_system_pio_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] out_port;

    soc_system_pio_blink_if bus ();

    soc_system_pio_blink #(
        .WIDTH        (8),
        .RESET_VALUE  (32'h0000_007F),
        .PRESCALE_W   (32),
        .PERIOD_RESET (32'd25000000)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .avs      (bus),
        .out_port (out_port)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] exp_rd;
        logic [7:0]  exp_out;
    } exp_t;

    exp_t sb_q[$];
    logic obs_valid = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Monitor: pops one expectation per observation strobe and compares.
    always @(negedge clk) begin
        if (obs_valid) begin
            exp_t e;
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_underflow: observation with empty queue");
            end else begin
                e = sb_q.pop_front();
                n_cmp++;
                if (bus.readdata !== e.exp_rd) begin
                    n_bad++;
                    $display("FAIL %s readdata: got %h expected %h", e.name, bus.readdata, e.exp_rd);
                end
                n_cmp++;
                if (out_port !== e.exp_out) begin
                    n_bad++;
                    $display("FAIL %s out_port: got %h expected %h", e.name, out_port, e.exp_out);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        step();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic chk(input string name, input logic [2:0] a,
                       input logic [31:0] rd, input logic [7:0] o);
        exp_t e;
        e.name    = name;
        e.exp_rd  = rd;
        e.exp_out = o;
        bus.address = a;
        sb_q.push_back(e);
        obs_valid = 1'b1;
        @(negedge clk);
        #1;
        obs_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        bus.address    = ADDR_DATA;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'h0;
        repeat (3) step();
        reset = 1'b0;
        step();

        chk("rst_data", ADDR_DATA, 32'h7F, 8'h7F);
        chk("rst_mask", ADDR_BLINK_MASK, 32'h0, 8'h7F);
`ifdef PIO_BLINK_EN
        chk("rst_period", ADDR_BLINK_PERIOD, 32'd25000000, 8'h7F);
`else
        chk("rst_period", ADDR_BLINK_PERIOD, 32'h0, 8'h7F);
`endif
        chk("rst_status", ADDR_STATUS, 32'h0, 8'h7F);

        wr(ADDR_DATA, 32'hFFFF_FFA5);
        chk("data_wr", ADDR_DATA, 32'hA5, 8'hA5);
        bus.address    = ADDR_DATA;
        bus.writedata  = 32'h11;
        bus.write_n    = 1'b0;
        step();
        bus.write_n    = 1'b1;
        chk("no_cs", ADDR_DATA, 32'hA5, 8'hA5);

        wr(ADDR_DATA, 32'hA0);
        wr(ADDR_OUTSET, 32'h0F);
        chk("outset", ADDR_DATA, 32'hAF, 8'hAF);
        chk("outset_rd0", ADDR_OUTSET, 32'h0, 8'hAF);
        wr(ADDR_OUTCLEAR, 32'h81);
        chk("outclr", ADDR_DATA, 32'h2E, 8'h2E);
        chk("outclr_rd0", ADDR_OUTCLEAR, 32'h0, 8'h2E);
        wr(3'd6, 32'hFF);
        chk("addr6_ign", ADDR_DATA, 32'h2E, 8'h2E);
        chk("addr7_rd0", 3'd7, 32'h0, 8'h2E);

`ifdef PIO_BLINK_EN
        wr(ADDR_DATA, 32'h0);
        wr(ADDR_BLINK_MASK, 32'h3);
        chk("mask_rb", ADDR_BLINK_MASK, 32'h3, 8'h00);
        wr(ADDR_BLINK_PERIOD, 32'd4);
        for (int k = 0; k < 8; k++) begin
            chk("blink_p4", ADDR_STATUS, {31'd0, k >= 4}, (k >= 4) ? 8'h03 : 8'h00);
            step();
        end
        repeat (3) step();
        wr(ADDR_BLINK_PERIOD, 32'd4);
        for (int k = 0; k < 5; k++) begin
            chk("tc_override", ADDR_STATUS, {31'd0, k == 4}, (k == 4) ? 8'h03 : 8'h00);
            step();
        end
        wr(ADDR_BLINK_PERIOD, 32'd0);
        chk("p0_load", ADDR_STATUS, 32'h1, 8'h03);
        step();
        for (int k = 0; k < 4; k++) begin
            chk("p0_hold", ADDR_STATUS, 32'h0, 8'h00);
            step();
        end
        chk("period_rb", ADDR_BLINK_PERIOD, 32'h0, 8'h00);
        wr(ADDR_BLINK_PERIOD, 32'd1);
        step();
        chk("p1_a", ADDR_STATUS, 32'h1, 8'h03);
        step();
        chk("p1_b", ADDR_STATUS, 32'h0, 8'h00);
        step();
        chk("p1_c", ADDR_STATUS, 32'h1, 8'h03);
        reset = 1'b1;
        step();
        chk("midrst_status", ADDR_STATUS, 32'h0, 8'h7F);
        chk("midrst_data", ADDR_DATA, 32'h7F, 8'h7F);
        chk("midrst_mask", ADDR_BLINK_MASK, 32'h0, 8'h7F);
        chk("midrst_period", ADDR_BLINK_PERIOD, 32'd25000000, 8'h7F);
        reset = 1'b0;
        step();
        chk("post_rst", ADDR_STATUS, 32'h0, 8'h7F);
`else
        wr(ADDR_DATA, 32'h0);
        wr(ADDR_BLINK_MASK, 32'hFF);
        wr(ADDR_BLINK_PERIOD, 32'd1);
        wr(ADDR_STATUS, 32'hFF);
        chk("nb_mask_rd0", ADDR_BLINK_MASK, 32'h0, 8'h00);
        chk("nb_period_rd0", ADDR_BLINK_PERIOD, 32'h0, 8'h00);
        chk("nb_status_rd0", ADDR_STATUS, 32'h0, 8'h00);
        for (int k = 0; k < 4; k++) begin
            chk("nb_no_blink", ADDR_DATA, 32'h0, 8'h00);
            step();
        end
        wr(ADDR_DATA, 32'h55);
        chk("nb_data", ADDR_DATA, 32'h55, 8'h55);
        reset = 1'b1;
        step();
        chk("midrst_data", ADDR_DATA, 32'h7F, 8'h7F);
        reset = 1'b0;
        step();
        chk("post_rst", ADDR_DATA, 32'h7F, 8'h7F);
`endif

        step();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: got %0d entries left expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_soc_system_pio_blink

`default_nettype wire
